// File: rtl/lamp_timer_ctrl.sv
// lamp_timer_ctrl
//   Staircase lamp controller for three switches. Each raw switch is synchronised
//   and debounced. Any accepted change is a toggle request, combined by parity so
//   the lamp behaves like F = S1^S2^S3. While the lamp is on, an auto-off timer runs.
//   warn flags the final WARN_CYCLES cycles of the on period. tmo pulses for one
//   cycle when the timer switches the lamp off.
//
// Ports
//   clk         in   1  rising-edge clock
//   rst         in   1  synchronous, active-high reset
//   S1,S2,S3    in   1  raw asynchronous switch levels
//   F           out  1  lamp drive, 1 = on
//   warn        out  1  high during the last WARN_CYCLES cycles of the on period
//   tmo         out  1  one-cycle pulse when the lamp is switched off by timeout
//   toggle_cnt  out  8  count of accepted lamp toggles, wraps 255->0
module lamp_timer_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 20,
    parameter int unsigned WARN_CYCLES     = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       S1,
    input  logic       S2,
    input  logic       S3,
    output logic       F,
    output logic       warn,
    output logic       tmo,
    output logic [7:0] toggle_cnt
);

    localparam int unsigned DC_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned PC_W  = $clog2(DEBOUNCE_CYCLES + 2) + 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [DC_W-1:0]  DC_LAST  = DC_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(DEBOUNCE_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_WARN = TMR_W'(TIMEOUT_CYCLES - WARN_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_ON,
        ST_WARN
    } state_t;

    logic [2:0]      raw;
    logic [2:0]      sync1;
    logic [2:0]      s;
    logic [2:0]      db;
    logic [2:0]      evt;
    logic [DC_W-1:0] dc [3];
    logic [PC_W-1:0] pc;
    logic            primed;
    logic            p;

    state_t          state;
    state_t          state_nx;
    logic [TMR_W-1:0] tmr;
    logic [TMR_W-1:0] tmr_nx;
    logic [7:0]      cnt_nx;
    logic            tmo_nx;

    assign raw = {S3, S2, S1};

    // Synchroniser, priming and per-switch debounce. During priming, db simply
    // follows the synchronised level. As a result, whatever the switches read
    // at reset becomes the baseline and never counts as a change.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '0;
            s      <= '0;
            db     <= '0;
            evt    <= '0;
            pc     <= '0;
            primed <= 1'b0;
            p      <= 1'b0;
            for (int unsigned i = 0; i < 3; i++) begin
                dc[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            s     <= sync1;
            // Odd number of simultaneous accepted changes toggles the lamp.
            p     <= ^evt;
            if (!primed) begin
                pc <= pc + 1'b1;
                if (pc == PC_LAST) begin
                    primed <= 1'b1;
                end
            end
            for (int unsigned i = 0; i < 3; i++) begin
                evt[i] <= 1'b0;
                if (!primed) begin
                    db[i] <= s[i];
                    dc[i] <= '0;
                end else if (s[i] == db[i]) begin
                    dc[i] <= '0;
                end else if (dc[i] == DC_LAST) begin
                    db[i]  <= s[i];
                    dc[i]  <= '0;
                    evt[i] <= 1'b1;
                end else begin
                    dc[i] <= dc[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_OFF;
            tmr        <= '0;
            toggle_cnt <= '0;
            tmo        <= 1'b0;
        end else begin
            state      <= state_nx;
            tmr        <= tmr_nx;
            toggle_cnt <= cnt_nx;
            tmo        <= tmo_nx;
        end
    end

    // A toggle request is checked before the timer. When a toggle and the
    // timeout land on the same cycle, the toggle wins and no tmo pulse is made.
    always_comb begin
        state_nx = state;
        tmr_nx   = tmr;
        cnt_nx   = toggle_cnt;
        tmo_nx   = 1'b0;
        case (state)
            ST_OFF: begin
                if (p) begin
                    state_nx = ST_ON;
                    tmr_nx   = '0;
                    cnt_nx   = toggle_cnt + 8'd1;
                end
            end
            ST_ON: begin
                if (p) begin
                    state_nx = ST_OFF;
                    cnt_nx   = toggle_cnt + 8'd1;
                end else begin
                    tmr_nx = tmr + 1'b1;
                    if (tmr == TMR_WARN) begin
                        state_nx = ST_WARN;
                    end
                end
            end
            ST_WARN: begin
                if (p) begin
                    state_nx = ST_OFF;
                    cnt_nx   = toggle_cnt + 8'd1;
                end else begin
                    tmr_nx = tmr + 1'b1;
                    if (tmr == TMR_LAST) begin
                        state_nx = ST_OFF;
                        tmo_nx   = 1'b1;
                    end
                end
            end
            default: begin
                state_nx = ST_OFF;
            end
        endcase
    end

    assign F    = (state == ST_ON) || (state == ST_WARN);
    assign warn = (state == ST_WARN);

endmodule
